// File: rtl/morph_filter.sv
// Binary erode/dilate over a KxK trailing window, using K-1 circular line buffers.
// Latency: 1 cycle from pix_i/de_i to pix_o/de_o.
// No backpressure: one pixel per PCLK is accepted whenever de_i is high.
module morph_filter #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 3,
   parameter int CNT_W = 12
) (
   input  logic             PCLK,
   input  logic             RST_N,
   input  logic [CNT_W-1:0] VtcHCnt,
   input  logic [CNT_W-1:0] VtcVCnt,
   input  logic             de_i,
   input  logic             pix_i,
   input  logic             mode,
   output logic             de_o,
   output logic             pix_o,
   output logic             mode_act
);

   // Slot counter is at least one bit wide so that K=2 (a single buffer) still elaborates.
   localparam int SLOT_W = (K > 2) ? $clog2(K-1) : 1;
   localparam int N_BUF  = 1 << SLOT_W;
   localparam int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   // Line buffers are deliberately left out of reset; frame_ok masks their stale contents.
   logic [IMG_W-1:0]  lbuf [N_BUF];
   logic [SLOT_W-1:0] wr_slot;
   logic [SLOT_W-1:0] cur_slot;
   logic              frame_ok;

   // win[r][c]: r = rows back from the current line, c = K-1 is the newest column.
   logic [K-1:0]      win     [K];
   logic [K-1:0]      win_nxt [K];
   logic [K-1:0]      new_col;

   logic              in_range;
   logic              valid;
   logic              frame_start;
   logic              line_end;
   logic              first_col;
   logic              mode_eff;
   logic              ok_eff;
   logic              res_and;
   logic              res_or;
   logic              res;
   logic [AW-1:0]     addr;

   // Buffer holding line v-r, given the buffer being written for line v.
   function automatic logic [SLOT_W-1:0] row_slot(input logic [SLOT_W-1:0] s, input int r);
      int t;
      t = int'(s) - r;
      if (t < 0) t = t + (K - 1);
      return SLOT_W'(t);
   endfunction

   // Qualify the incoming pixel; out-of-range coordinates behave exactly like a blank cycle.
   always_comb begin
      in_range    = ({1'b0, VtcHCnt} < (CNT_W+1)'(IMG_W)) &&
                    ({1'b0, VtcVCnt} < (CNT_W+1)'(IMG_H));
      valid       = de_i && in_range;
      first_col   = (VtcHCnt == '0);
      frame_start = valid && first_col && (VtcVCnt == '0);
      line_end    = valid && (VtcHCnt == CNT_W'(IMG_W - 1));
      // The frame-start pixel must already land in slot 0 and use the newly latched mode.
      cur_slot    = frame_start ? '0 : wr_slot;
      mode_eff    = frame_start ? mode : mode_act;
      ok_eff      = frame_start | frame_ok;
      addr        = VtcHCnt[AW-1:0];
   end

   // Build the next window: new column from pix_i plus buffered rows, rows above the image masked.
   always_comb begin
      new_col    = '0;
      new_col[0] = pix_i;
      for (int r = 1; r < K; r++) begin
         new_col[r] = (VtcVCnt >= CNT_W'(r)) ? lbuf[row_slot(cur_slot, r)][addr] : 1'b0;
      end
      for (int r = 0; r < K; r++) begin
         win_nxt[r] = '0;
         for (int c = 0; c < K-1; c++) begin
            // Column 0 of a line must not see the previous line's right edge.
            win_nxt[r][c] = first_col ? 1'b0 : win[r][c+1];
         end
         win_nxt[r][K-1] = new_col[r];
      end
   end

   // Reduce the next window: AND for erode, OR for dilate (out-of-image taps are 0 in both).
   always_comb begin
      res_and = 1'b1;
      res_or  = 1'b0;
      for (int r = 0; r < K; r++) begin
         res_and = res_and & (&win_nxt[r]);
         res_or  = res_or  | (|win_nxt[r]);
      end
      res = mode_eff ? res_or : res_and;
   end

   // Line buffer write for the current line; the read above sees the old contents this cycle.
   always_ff @(posedge PCLK) begin
      if (valid) begin
         lbuf[cur_slot][addr] <= pix_i;
      end
   end

   // Window, slot ring, frame tracking and the registered outputs.
   always_ff @(posedge PCLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_slot  <= '0;
         frame_ok <= 1'b0;
         mode_act <= 1'b0;
         de_o     <= 1'b0;
         pix_o    <= 1'b0;
         for (int r = 0; r < K; r++) begin
            win[r] <= '0;
         end
      end else begin
         de_o  <= valid;
         pix_o <= valid & ok_eff & res;
         if (valid) begin
            for (int r = 0; r < K; r++) begin
               win[r] <= win_nxt[r];
            end
            if (line_end) begin
               wr_slot <= (cur_slot == SLOT_W'(K - 2)) ? '0 : cur_slot + SLOT_W'(1);
            end else begin
               wr_slot <= cur_slot;
            end
         end
         if (frame_start) begin
            mode_act <= mode;
            frame_ok <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_morph_filter.sv
// Bench for morph_filter: three instances (K=3, K=2, K=5) share one pixel stream.
// Each output is compared one cycle later against a direct window computation over a frame image.
// No backpressure to model; gaps and out-of-range cycles are injected at random.
module tb_morph_filter;
   localparam int W  = 16;
   localparam int H  = 12;
   localparam int CW = 6;
   localparam int ND = 3;

   logic          PCLK = 1'b0;
   logic          RST_N;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] vcnt;
   logic          de;
   logic          pix;
   logic          mode_in;
   logic          de_o_k     [ND];
   logic          pix_o_k    [ND];
   logic          mode_act_k [ND];

   int n_tests = 0;
   int n_fail  = 0;
   bit img [H][W];
   bit pat [H][W];
   bit ok_m   = 1'b0;
   bit mode_m = 1'b0;
   int ones [ND];

   always #5 PCLK = ~PCLK;

   morph_filter #(.IMG_W(W), .IMG_H(H), .K(3), .CNT_W(CW)) u_k3 (
      .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(hcnt), .VtcVCnt(vcnt), .de_i(de), .pix_i(pix),
      .mode(mode_in), .de_o(de_o_k[0]), .pix_o(pix_o_k[0]), .mode_act(mode_act_k[0]));
   morph_filter #(.IMG_W(W), .IMG_H(H), .K(2), .CNT_W(CW)) u_k2 (
      .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(hcnt), .VtcVCnt(vcnt), .de_i(de), .pix_i(pix),
      .mode(mode_in), .de_o(de_o_k[1]), .pix_o(pix_o_k[1]), .mode_act(mode_act_k[1]));
   morph_filter #(.IMG_W(W), .IMG_H(H), .K(5), .CNT_W(CW)) u_k5 (
      .PCLK(PCLK), .RST_N(RST_N), .VtcHCnt(hcnt), .VtcVCnt(vcnt), .de_i(de), .pix_i(pix),
      .mode(mode_in), .de_o(de_o_k[2]), .pix_o(pix_o_k[2]), .mode_act(mode_act_k[2]));

   function automatic int kof(input int i);
      return (i == 0) ? 3 : (i == 1) ? 2 : 5;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: erode/dilate of the KxK trailing window, pixels outside the image count as 0.
   function automatic bit ref_pix(input int k, input int h, input int v, input bit md);
      bit acc;
      bit p;
      acc = ~md;
      for (int dy = 0; dy < k; dy++) begin
         for (int dx = 0; dx < k; dx++) begin
            p = (v - dy >= 0 && h - dx >= 0) ? img[v-dy][h-dx] : 1'b0;
            if (md) acc = acc | p;
            else    acc = acc & p;
         end
      end
      return acc;
   endfunction

   task automatic step(input bit d, input int h, input int v, input bit p);
      bit vld;
      bit exp_p [ND];
      de   = d;
      hcnt = CW'(h);
      vcnt = CW'(v);
      pix  = p;
      vld  = d && h < W && v < H;
      if (vld && h == 0 && v == 0) begin
         ok_m   = 1'b1;
         mode_m = mode_in;
      end
      if (vld) img[v][h] = p;
      for (int k = 0; k < ND; k++) begin
         exp_p[k] = (vld && ok_m) ? ref_pix(kof(k), h, v, mode_m) : 1'b0;
      end
      @(posedge PCLK);
      #1;
      for (int k = 0; k < ND; k++) begin
         check($sformatf("de_o K%0d h%0d v%0d", kof(k), h, v), int'(de_o_k[k]), int'(vld));
         check($sformatf("pix_o K%0d h%0d v%0d", kof(k), h, v), int'(pix_o_k[k]), int'(exp_p[k]));
         check($sformatf("mode_act K%0d h%0d v%0d", kof(k), h, v), int'(mode_act_k[k]), int'(mode_m));
         ones[k] += int'(pix_o_k[k]);
      end
   endtask

   task automatic pulse_reset();
      #1;
      RST_N = 1'b0;
      #1;
      for (int k = 0; k < ND; k++) begin
         check($sformatf("rst pix_o K%0d", kof(k)), int'(pix_o_k[k]), 0);
         check($sformatf("rst de_o K%0d", kof(k)), int'(de_o_k[k]), 0);
         check($sformatf("rst mode_act K%0d", kof(k)), int'(mode_act_k[k]), 0);
      end
      ok_m   = 1'b0;
      mode_m = 1'b0;
      RST_N  = 1'b1;
   endtask

   // kind: 0 all ones, 1 single dot at (6,5), 2 2x2 block at h 4..5 v 3..4, 3 random
   task automatic set_pat(input int kind);
      for (int v = 0; v < H; v++) begin
         for (int h = 0; h < W; h++) begin
            case (kind)
               0:       pat[v][h] = 1'b1;
               1:       pat[v][h] = (h == 6 && v == 5);
               2:       pat[v][h] = (h >= 4 && h <= 5 && v >= 3 && v <= 4);
               default: pat[v][h] = ($urandom_range(0, 99) < 60);
            endcase
         end
      end
   endtask

   // gap_max = 0 gives a back-to-back raster with no blanking at all.
   task automatic run_frame(input bit md, input int gap_max, input int tog_v, input int rst_v);
      int n;
      mode_in = md;
      for (int k = 0; k < ND; k++) ones[k] = 0;
      for (int v = 0; v < H; v++) begin
         for (int h = 0; h < W; h++) begin
            if (v == tog_v && h == 5) mode_in = ~mode_in;
            if (v == rst_v && h == 7) pulse_reset();
            if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
               n = int'($urandom_range(1, gap_max));
               for (int g = 0; g < n; g++) begin
                  step(1'b0, int'($urandom_range(0, W + 3)), v, 1'($urandom_range(0, 1)));
               end
            end
            step(1'b1, h, v, pat[v][h]);
         end
         if (gap_max > 0) begin
            step(1'b1, W + int'($urandom_range(0, 3)), v, 1'b1);
            step(1'b0, 0, v, 1'b0);
         end
      end
      if (gap_max > 0) begin
         step(1'b1, 2, H + int'($urandom_range(0, 3)), 1'b1);
         step(1'b0, 0, 0, 1'b0);
      end
   endtask

   initial begin
      RST_N   = 1'b0;
      de      = 1'b0;
      pix     = 1'b0;
      mode_in = 1'b0;
      hcnt    = '0;
      vcnt    = '0;
      repeat (3) @(posedge PCLK);
      #1;
      for (int k = 0; k < ND; k++) begin
         check($sformatf("reset pix_o K%0d", kof(k)), int'(pix_o_k[k]), 0);
         check($sformatf("reset de_o K%0d", kof(k)), int'(de_o_k[k]), 0);
         check($sformatf("reset mode_act K%0d", kof(k)), int'(mode_act_k[k]), 0);
      end
      RST_N = 1'b1;

      // Pixels before any frame start must stay masked.
      for (int h = 3; h < W; h++) step(1'b1, h, 3, 1'b1);
      step(1'b0, 0, 0, 1'b0);

      set_pat(0);
      run_frame(1'b0, 0, -1, -1);
      check("ones all-ones erode K3", ones[0], (W-2)*(H-2));
      check("ones all-ones erode K2", ones[1], (W-1)*(H-1));

      set_pat(1);
      run_frame(1'b1, 3, -1, -1);
      check("ones dot dilate K3", ones[0], 9);
      check("ones dot dilate K2", ones[1], 4);

      set_pat(2);
      run_frame(1'b0, 2, -1, -1);
      check("ones 2x2 erode K3", ones[0], 0);
      check("ones 2x2 erode K2", ones[1], 1);

      set_pat(3);
      run_frame(1'b1, 5, -1, -1);
      set_pat(3);
      run_frame(1'b0, 5, -1, -1);
      set_pat(3);
      run_frame(1'b0, 5, 4, -1);
      set_pat(3);
      run_frame(1'b1, 0, 7, -1);
      set_pat(3);
      run_frame(1'b1, 4, -1, 6);
      set_pat(3);
      run_frame(1'b0, 5, -1, -1);
      set_pat(3);
      run_frame(1'b1, 0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
